fetch_unit: RTL

//  Instruction-fetch stage of processor_2. Owns the program counter and drives
//  the instruction ROM address. Hands one instruction per cycle to decode.

---
 rtl/fetch_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: owns the PC, drives the ROM address and hands one instruction per cycle to decode
module fetch_unit #(
  parameter int unsigned        PC_W       = 8,
  parameter int unsigned        INSTR_W    = 9,
  parameter logic [PC_W-1:0]    START_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic               clock,
  input  logic               init_n,
  input  logic               restart,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    instr_pc_q;
  logic               valid_q;
  logic               done_q;
  logic               halt_seen;

  // The HALT word retires on the first unstalled edge after it reaches decode.
  assign halt_seen = valid_q && (instr_q == HALT_INSTR);

  always_ff @(posedge clock or negedge init_n) begin
    if (!init_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (restart) begin
      state_q <= ST_RUN;
      pc_q    <= START_PC;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            if (halt_seen) begin
              state_q <= ST_HALT;
              done_q  <= 1'b1;
              valid_q <= 1'b0;
            end else if (branch_taken) begin
              // Wrong-path word at the old PC is dropped, leaving one bubble.
              pc_q    <= branch_target;
              valid_q <= 1'b0;
            end else begin
              instr_q    <= imem_data;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              pc_q       <= pc_q + PC_ONE;
            end
          end
        end
        ST_HALT: begin
          done_q  <= 1'b1;
          valid_q <= 1'b0;
        end
        default: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

endmodule
